// File: rtl/sobel_edge_filter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sobel_edge_filter
//
// Sobel gradient stage fed by the 3x3 grayscale neighbourhood of the matrix
// converter. For every tagged matrix it computes |Gx|+|Gy|, saturates the sum
// to the pixel width and flags an edge against a runtime threshold. The result
// leaves through three registered stages with a throughput of one per cycle.
//
// Ports
//   I_CLK                 clock, rising edge
//   I_RESET               asynchronous active-low reset
//   I_ENABLE              advance all stages (bubbles included) when high
//   I_PIXEL_COLUMN/ROW    tag of the incoming matrix
//   I_PIXEL_MATRIX        {tl,t,tr,ml,mr,bl,b,br}, tl in the MSBs
//   I_PIXEL_MATRIX_READY  incoming matrix is valid
//   I_THRESHOLD           edge threshold, sampled by the last stage
//   O_PIXEL_COLUMN/ROW    tag of O_PIXEL
//   O_PIXEL               saturated gradient magnitude
//   O_EDGE                O_PIXEL >= threshold (0 whenever output invalid)
//   O_PIXEL_READY         outputs valid
// -----------------------------------------------------------------------------
module sobel_edge_filter #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_SUBPIXEL_DEPTH    = 8,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int P_MATRIX_BITS       = 8 * P_SUBPIXEL_DEPTH
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
  input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
  input  logic [P_MATRIX_BITS-1:0]       I_PIXEL_MATRIX,
  input  logic                           I_PIXEL_MATRIX_READY,
  input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic [P_SUBPIXEL_DEPTH-1:0]    O_PIXEL,
  output logic                           O_EDGE,
  output logic                           O_PIXEL_READY
);

  localparam int D  = P_SUBPIXEL_DEPTH;
  localparam int GW = D + 4;  // signed gradient width
  localparam int AW = D + 3;  // magnitude width, holds 4*(2^D-1)
  localparam logic [GW-1:0] SAT_MAX = GW'((1 << D) - 1);

  // Position of each neighbour inside I_PIXEL_MATRIX, in units of D bits.
  localparam int IDX_TL = 7;
  localparam int IDX_T  = 6;
  localparam int IDX_TR = 5;
  localparam int IDX_ML = 4;
  localparam int IDX_MR = 3;
  localparam int IDX_BL = 2;
  localparam int IDX_B  = 1;
  localparam int IDX_BR = 0;

  // Valid bit and position tag travel together through every stage.
  typedef struct packed {
    logic                           valid;
    logic [P_FRAME_COLUMN_BITS-1:0] col;
    logic [P_FRAME_ROW_BITS-1:0]    row;
  } tag_t;

  function automatic logic [AW-1:0] abs_trunc(input logic signed [GW-1:0] v);
    // |v| never exceeds 4*(2^D-1), so dropping the top bit loses nothing.
    return v[GW-1] ? AW'(-v) : AW'(v);
  endfunction

  // ---------------------------------------------------------------- S1 math
  logic signed [GW-1:0] px [8];
  logic signed [GW-1:0] gx_c;
  logic signed [GW-1:0] gy_c;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      px[i] = $signed({{4{1'b0}}, I_PIXEL_MATRIX[i*D +: D]});
    end
    gx_c = (px[IDX_TR] + (px[IDX_MR] <<< 1) + px[IDX_BR])
         - (px[IDX_TL] + (px[IDX_ML] <<< 1) + px[IDX_BL]);
    gy_c = (px[IDX_BL] + (px[IDX_B]  <<< 1) + px[IDX_BR])
         - (px[IDX_TL] + (px[IDX_T]  <<< 1) + px[IDX_TR]);
  end

  // ---------------------------------------------------------- stage registers
  tag_t                 s1_tag_q, s1_tag_d;
  logic signed [GW-1:0] s1_gx_q, s1_gx_d;
  logic signed [GW-1:0] s1_gy_q, s1_gy_d;

  tag_t                 s2_tag_q, s2_tag_d;
  logic [AW-1:0]        s2_abs_gx_q, s2_abs_gx_d;
  logic [AW-1:0]        s2_abs_gy_q, s2_abs_gy_d;

  tag_t                 s3_tag_q, s3_tag_d;
  logic [D-1:0]         s3_pix_q, s3_pix_d;
  logic                 s3_edge_q, s3_edge_d;

  // ---------------------------------------------------------------- S3 math
  logic [GW-1:0] sum_c;
  logic [D-1:0]  sat_pix_c;

  always_comb begin
    sum_c     = {1'b0, s2_abs_gx_q} + {1'b0, s2_abs_gy_q};
    sat_pix_c = (sum_c > SAT_MAX) ? {D{1'b1}} : sum_c[D-1:0];
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    // NOTE: every _d starts as its _q (hold), so no path leaves a signal
    // unassigned and no latch is inferred.
    s1_tag_d    = s1_tag_q;
    s1_gx_d     = s1_gx_q;
    s1_gy_d     = s1_gy_q;
    s2_tag_d    = s2_tag_q;
    s2_abs_gx_d = s2_abs_gx_q;
    s2_abs_gy_d = s2_abs_gy_q;
    s3_tag_d    = s3_tag_q;
    s3_pix_d    = s3_pix_q;
    s3_edge_d   = s3_edge_q;

    if (I_ENABLE) begin
      s1_tag_d    = '{valid: I_PIXEL_MATRIX_READY, col: I_PIXEL_COLUMN, row: I_PIXEL_ROW};
      s1_gx_d     = gx_c;
      s1_gy_d     = gy_c;

      s2_tag_d    = s1_tag_q;
      s2_abs_gx_d = abs_trunc(s1_gx_q);
      s2_abs_gy_d = abs_trunc(s1_gy_q);

      s3_tag_d    = s2_tag_q;
      s3_pix_d    = sat_pix_c;
      // Gated by valid so a bubble never reports an edge.
      s3_edge_d   = s2_tag_q.valid && (sat_pix_c >= I_THRESHOLD);
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      // NOTE: all stage registers clear on reset, so outputs are zero at once
      // and in-flight data is discarded.
      s1_tag_q    <= '0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s2_tag_q    <= '0;
      s2_abs_gx_q <= '0;
      s2_abs_gy_q <= '0;
      s3_tag_q    <= '0;
      s3_pix_q    <= '0;
      s3_edge_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every stage reads the previous cycle's
      // value of the stage before it.
      s1_tag_q    <= s1_tag_d;
      s1_gx_q     <= s1_gx_d;
      s1_gy_q     <= s1_gy_d;
      s2_tag_q    <= s2_tag_d;
      s2_abs_gx_q <= s2_abs_gx_d;
      s2_abs_gy_q <= s2_abs_gy_d;
      s3_tag_q    <= s3_tag_d;
      s3_pix_q    <= s3_pix_d;
      s3_edge_q   <= s3_edge_d;
    end
  end

  assign O_PIXEL_COLUMN = s3_tag_q.col;
  assign O_PIXEL_ROW    = s3_tag_q.row;
  assign O_PIXEL        = s3_pix_q;
  assign O_EDGE         = s3_edge_q;
  assign O_PIXEL_READY  = s3_tag_q.valid;

endmodule

// File: tb/tb_sobel_edge_filter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sobel_edge_filter
//
// Directed scenarios plus a randomized run of sobel_edge_filter against a
// reference model: the output after each enabled edge is the Sobel magnitude
// of the item accepted two enabled edges earlier, thresholded with the value
// present at that edge.
// -----------------------------------------------------------------------------
module tb_sobel_edge_filter;

  logic        I_CLK;
  logic        I_RESET;
  logic        I_ENABLE;
  logic [9:0]  I_PIXEL_COLUMN;
  logic [8:0]  I_PIXEL_ROW;
  logic [63:0] I_PIXEL_MATRIX;
  logic        I_PIXEL_MATRIX_READY;
  logic [7:0]  I_THRESHOLD;
  logic [9:0]  O_PIXEL_COLUMN;
  logic [8:0]  O_PIXEL_ROW;
  logic [7:0]  O_PIXEL;
  logic        O_EDGE;
  logic        O_PIXEL_READY;

  sobel_edge_filter dut (
    .I_CLK                (I_CLK),
    .I_RESET              (I_RESET),
    .I_ENABLE             (I_ENABLE),
    .I_PIXEL_COLUMN       (I_PIXEL_COLUMN),
    .I_PIXEL_ROW          (I_PIXEL_ROW),
    .I_PIXEL_MATRIX       (I_PIXEL_MATRIX),
    .I_PIXEL_MATRIX_READY (I_PIXEL_MATRIX_READY),
    .I_THRESHOLD          (I_THRESHOLD),
    .O_PIXEL_COLUMN       (O_PIXEL_COLUMN),
    .O_PIXEL_ROW          (O_PIXEL_ROW),
    .O_PIXEL              (O_PIXEL),
    .O_EDGE               (O_EDGE),
    .O_PIXEL_READY        (O_PIXEL_READY)
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        v;
    logic [63:0] m;
    logic [9:0]  c;
    logic [8:0]  r;
  } item_t;

  item_t       hist[$];     // last three items accepted on enabled edges
  logic [28:0] exp_vec;     // {ready, edge, pixel, col, row}
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [63:0] mat(input logic [7:0] tl, t, tr, ml, mr, bl, b, br);
    return {tl, t, tr, ml, mr, bl, b, br};
  endfunction

  // Sobel magnitude from the textbook formula, saturated to 8 bits.
  function automatic int ref_mag(input logic [63:0] m);
    int tl, t, tr, ml, mr, bl, b, br, gx, gy, s;
    tl = int'(m[63:56]); t  = int'(m[55:48]); tr = int'(m[47:40]);
    ml = int'(m[39:32]); mr = int'(m[31:24]);
    bl = int'(m[23:16]); b  = int'(m[15:8]);  br = int'(m[7:0]);
    gx = (tr + 2*mr + br) - (tl + 2*ml + bl);
    gy = (bl + 2*b + br) - (tl + 2*t + tr);
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic logic [28:0] obs();
    return {O_PIXEL_READY, O_EDGE, O_PIXEL, O_PIXEL_COLUMN, O_PIXEL_ROW};
  endfunction

  // Pixel and tags are don't-care on an invalid output; ready and edge are not.
  function automatic logic [28:0] vmask(input logic v);
    return v ? '1 : {2'b11, 27'd0};
  endfunction

  function automatic logic [63:0] rand_mat();
    logic [63:0] m;
    int base, p;
    if ($urandom_range(0, 1) == 0) begin
      m = {$urandom, $urandom};
    end else begin
      base = $urandom_range(0, 255);
      for (int i = 0; i < 8; i++) begin
        p = base + $urandom_range(0, 15) - 7;
        p = (p < 0) ? 0 : (p > 255 ? 255 : p);
        m[i*8 +: 8] = 8'(p);
      end
    end
    return m;
  endfunction

  // Apply one cycle of inputs, clock it, and advance the reference model.
  task automatic cycle(input logic en, input logic rdy, input logic [63:0] m,
                       input logic [9:0] c, input logic [8:0] r, input logic [7:0] thr);
    item_t it;
    int    p;
    I_ENABLE             = en;
    I_PIXEL_MATRIX_READY = rdy;
    I_PIXEL_MATRIX       = m;
    I_PIXEL_COLUMN       = c;
    I_PIXEL_ROW          = r;
    I_THRESHOLD          = thr;
    @(posedge I_CLK);
    #1;
    if (en && I_RESET) begin
      it.v = rdy; it.m = m; it.c = c; it.r = r;
      hist.push_back(it);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3 && hist[0].v) begin
        p = ref_mag(hist[0].m);
        exp_vec = {1'b1, p >= int'(thr), 8'(p), hist[0].c, hist[0].r};
      end else begin
        exp_vec = '0;
      end
    end
  endtask

  task automatic test_reset();
    I_RESET = 1'b1;
    I_ENABLE = 1'b0; I_PIXEL_MATRIX_READY = 1'b0; I_PIXEL_MATRIX = '0;
    I_PIXEL_COLUMN = '0; I_PIXEL_ROW = '0; I_THRESHOLD = '0;
    #2 I_RESET = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", obs());
    end
    hist.delete(); exp_vec = '0;
    // Reset dominates enable with valid data presented.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, mat(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF), 10'd3, 9'd4, 8'h00);
      n_cmp++;
      if (obs() !== '0) begin
        n_err++; $display("FAIL reset_hold cyc%0d: got %h want 0", i, obs());
      end
    end
    I_RESET = 1'b1;
  endtask

  task automatic test_flat();
    logic [63:0] m;
    m = mat(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 0, m, 10'd5, 9'd7, 8'h40);
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL flat step%0d: got %h want %h", i, obs(), exp_vec);
      end
    end
    n_cmp++;
    if (obs() !== {1'b1, 1'b0, 8'h00, 10'd5, 9'd7}) begin
      n_err++; $display("FAIL flat_value: got %h want %h", obs(), {1'b1, 1'b0, 8'h00, 10'd5, 9'd7});
    end
  endtask

  task automatic test_vertical_edge();
    logic [63:0] m;
    m = mat(8'h00, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 0, m, 10'd1, 9'd2, 8'hFE);
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL vertical step%0d: got %h want %h", i, obs(), exp_vec);
      end
    end
    n_cmp++;
    if (obs() !== {1'b1, 1'b1, 8'hFF, 10'd1, 9'd2}) begin
      n_err++; $display("FAIL vertical_sat: got %h want %h", obs(), {1'b1, 1'b1, 8'hFF, 10'd1, 9'd2});
    end
  endtask

  task automatic test_threshold_boundary();
    logic [63:0] m;
    logic [7:0]  thr;
    m = mat(8'h10, 8'h10, 8'h11, 8'h10, 8'h11, 8'h10, 8'h10, 8'h11);
    for (int k = 0; k < 2; k++) begin
      thr = (k == 0) ? 8'h04 : 8'h05;
      for (int i = 0; i < 3; i++) begin
        cycle(1'b1, i == 0, m, 10'd100, 9'd200, thr);
        n_cmp++;
        if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
          n_err++; $display("FAIL small_grad thr%0d step%0d: got %h want %h", thr, i, obs(), exp_vec);
        end
      end
      n_cmp++;
      if (obs() !== {1'b1, k == 0, 8'h04, 10'd100, 9'd200}) begin
        n_err++; $display("FAIL small_grad_value thr%0d: got %h want %h", thr, obs(),
                          {1'b1, k == 0, 8'h04, 10'd100, 9'd200});
      end
    end
  endtask

  task automatic test_stall();
    // Stalls after the 2nd item, and again while item 1 is on the outputs.
    logic       en_seq  [12] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    logic       rdy_seq [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [9:0] tag_seq [12] = '{0, 1, 9, 9, 2, 3, 9, 9, 9, 9, 9, 9};
    logic [9:0] got[$];
    bit         ok;
    for (int i = 0; i < 12; i++) begin
      cycle(en_seq[i], rdy_seq[i], rand_mat(), tag_seq[i], 9'(i), 8'h80);
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL stall cyc%0d: got %h want %h", i, obs(), exp_vec);
      end
      if (en_seq[i] && O_PIXEL_READY === 1'b1) got.push_back(O_PIXEL_COLUMN);
    end
    ok = (got.size() == 4);
    for (int i = 0; i < got.size() && i < 4; i++) if (got[i] !== 10'(i)) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL stall_order: got %0d items %p want 4 items tags 0..3", got.size(), got);
    end
  endtask

  task automatic test_bubbles();
    logic [4:0] pattern = 5'b10110;
    logic [4:0] rdy_obs, edge_obs;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, (i < 5) ? pattern[4-i] : 1'b0, rand_mat(), 10'(40 + i), 9'(i), 8'h00);
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL bubbles cyc%0d: got %h want %h", i, obs(), exp_vec);
      end
      if (i >= 2 && i < 7) begin
        rdy_obs[6-i]  = O_PIXEL_READY;
        edge_obs[6-i] = O_EDGE;
      end
    end
    // Threshold 0 makes every valid slot an edge, so both must follow the pattern.
    n_cmp++;
    if ({rdy_obs, edge_obs} !== {pattern, pattern}) begin
      n_err++; $display("FAIL bubbles_pattern: got ready %b edge %b want %b", rdy_obs, edge_obs, pattern);
    end
  endtask

  task automatic test_reset_mid_stream();
    int first_ready;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, rand_mat(), 10'(20 + i), 9'd11, 8'h00);
    end
    n_cmp++;
    if (O_PIXEL_READY !== 1'b1) begin
      n_err++; $display("FAIL midreset_inflight: got ready %b want 1", O_PIXEL_READY);
    end
    #3 I_RESET = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL midreset_async: got %h want 0", obs());
    end
    hist.delete(); exp_vec = '0;
    cycle(1'b1, 1'b1, rand_mat(), 10'd30, 9'd11, 8'h00);
    I_RESET = 1'b1;
    first_ready = -1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, i == 0, rand_mat(), 10'd31, 9'd12, 8'h00);
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL midreset cyc%0d: got %h want %h", i, obs(), exp_vec);
      end
      if (first_ready < 0 && O_PIXEL_READY === 1'b1) first_ready = i;
    end
    n_cmp++;
    if (first_ready != 2) begin
      n_err++; $display("FAIL midreset_first_ready: got cycle %0d want 2", first_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, rand_mat(),
            10'($urandom), 9'($urandom), 8'($urandom));
      n_cmp++;
      if (((obs() ^ exp_vec) & vmask(exp_vec[28])) !== '0) begin
        n_err++; $display("FAIL random cyc%0d: got %h want %h", i, obs(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vertical_edge();
    test_threshold_boundary();
    test_stall();
    test_bubbles();
    test_reset_mid_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
